// File: rtl/multi_pipe_param_if.sv
// Operand/result handshake bundle for the pipelined multiplier.
// The slave side is the multiplier; the master side is its upstream/downstream.
interface multi_pipe_param_if #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) ();
  logic                             mul_en_in;
  logic                             mul_rdy_in;
  logic [WIDTH-1:0]                 mul_a;
  logic [WIDTH-1:0]                 mul_b;
  logic                             mul_signed;
  logic                             mul_en_out;
  logic                             mul_rdy_out;
  logic [2*WIDTH-1:0]               mul_out;
  logic [$clog2(LATENCY+1)-1:0]     inflight;

  modport slave (
    input  mul_en_in, mul_a, mul_b, mul_signed, mul_rdy_out,
    output mul_rdy_in, mul_en_out, mul_out, inflight
  );

  modport master (
    output mul_en_in, mul_a, mul_b, mul_signed, mul_rdy_out,
    input  mul_rdy_in, mul_en_out, mul_out, inflight
  );
endinterface

// File: rtl/multi_pipe_param.sv
// LATENCY-stage signed/unsigned WIDTH x WIDTH multiplier with a single global
// stall: every stage advances together whenever the output slot can move.
module multi_pipe_param #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 4
) (
  input logic               clk,
  input logic               rst,
  multi_pipe_param_if.slave bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int EW  = WIDTH + 1;
  localparam int XW  = 2 * EW;
  localparam int LOW = WIDTH / 2;
  localparam int CW  = $clog2(LATENCY + 1);

  // One extra bit lets signed and unsigned operands share one signed multiplier.
  function automatic logic signed [EW-1:0] f_ext(input logic [WIDTH-1:0] v, input logic s);
    return $signed({s & v[WIDTH-1], v});
  endfunction

  logic                 w_adv;
  logic                 w_acc;
  logic                 w_ret;
  logic [LATENCY-1:0]   r_vld;
  logic [CW-1:0]        r_cnt;
  logic signed [EW-1:0] r_a_p0;
  logic signed [EW-1:0] r_b_p0;
  logic [PW-1:0]        w_pre;
  logic [PW-1:0]        r_out;

  assign w_adv = ~r_vld[LATENCY-1] | bus.mul_rdy_out;
  assign w_acc = bus.mul_en_in & w_adv;
  assign w_ret = r_vld[LATENCY-1] & bus.mul_rdy_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      if (w_adv) r_vld <= {r_vld[LATENCY-2:0], bus.mul_en_in};
      if (w_acc && !w_ret)      r_cnt <= r_cnt + 1'b1;
      else if (w_ret && !w_acc) r_cnt <= r_cnt - 1'b1;
    end
  end

  // p0: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_p0 <= '0;
      r_b_p0 <= '0;
    end else if (w_acc) begin
      r_a_p0 <= f_ext(bus.mul_a, bus.mul_signed);
      r_b_p0 <= f_ext(bus.mul_b, bus.mul_signed);
    end
  end

  generate
    if (LATENCY == 2) begin : g_l2
      assign w_pre = PW'(XW'(r_a_p0) * XW'(r_b_p0));
    end else begin : g_split
      logic signed [XW-1:0] r_lo_p1;
      logic signed [XW-1:0] r_hi_p1;
      logic [PW-1:0]        w_sum;

      // p1: multiplier split into an unsigned low half and a signed high half
      always_ff @(posedge clk) begin
        if (rst) begin
          r_lo_p1 <= '0;
          r_hi_p1 <= '0;
        end else if (w_adv && r_vld[0]) begin
          r_lo_p1 <= XW'(r_a_p0) * XW'($signed({1'b0, r_b_p0[LOW-1:0]}));
          r_hi_p1 <= XW'(r_a_p0) * XW'($signed(r_b_p0[EW-1:LOW]));
        end
      end

      assign w_sum = PW'(r_lo_p1 + (r_hi_p1 <<< LOW));

      if (LATENCY == 3) begin : g_l3
        assign w_pre = w_sum;
      end else begin : g_dly
        logic [PW-1:0] r_dly_p2 [LATENCY-3];

        // p2..: summed product, then plain delay stages up to the output slot
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int i = 0; i < LATENCY-3; i++) r_dly_p2[i] <= '0;
          end else if (w_adv) begin
            if (r_vld[1]) r_dly_p2[0] <= w_sum;
            for (int i = 1; i < LATENCY-3; i++)
              if (r_vld[i+1]) r_dly_p2[i] <= r_dly_p2[i-1];
          end
        end

        assign w_pre = r_dly_p2[LATENCY-4];
      end
    end
  endgenerate

  // Output stage: loads only when a valid result moves in, else holds.
  always_ff @(posedge clk) begin
    if (rst)                            r_out <= '0;
    else if (w_adv && r_vld[LATENCY-2]) r_out <= w_pre;
  end

  assign bus.mul_rdy_in = w_adv;
  assign bus.mul_en_out = r_vld[LATENCY-1];
  assign bus.mul_out    = r_out;
  assign bus.inflight   = r_cnt;
endmodule

// File: tb/tb_multi_pipe_param.sv
// Directed table-driven bench for multi_pipe_param at WIDTH=16, LATENCY=4.
module tb_multi_pipe_param;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int NV = 12;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;
  vec_t vt [NV];

  multi_pipe_param_if #(.WIDTH(W), .LATENCY(L)) bus ();

  multi_pipe_param #(.WIDTH(W), .LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic en, input vec_t v);
    bus.mul_en_in  = en;
    bus.mul_a      = v.a;
    bus.mul_b      = v.b;
    bus.mul_signed = v.s;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t idle;
    vec_t junk;
    int   peak;
    int   acc;
    int   ret;

    vt[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vt[1]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vt[2]  = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE};
    vt[3]  = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE};
    vt[4]  = '{16'h1234, 16'h0000, 1'b1, 32'h00000000};
    vt[5]  = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
    vt[6]  = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    vt[7]  = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vt[9]  = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vt[10] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1};
    vt[11] = '{16'hFFFB, 16'h0003, 1'b0, 32'h0002FFF1};
    idle = '0;
    junk = '{16'h5555, 16'h5555, 1'b0, 32'h0};

    // Reset held for two edges while upstream offers an operand
    rst = 1'b1;
    bus.mul_rdy_out = 1'b1;
    drive(1'b1, vt[0]);
    step();
    step();
    chk("rst_en_out", bus.mul_en_out, 0);
    chk("rst_mul_out", bus.mul_out, 0);
    chk("rst_inflight", bus.inflight, 0);
    rst = 1'b0;
    drive(1'b0, idle);
    #1;
    chk("rst_rdy_in", bus.mul_rdy_in, 1);

    // Back-to-back stream of the whole table, mixed signedness
    peak = 0;
    for (int c = 0; c <= NV + L - 1; c++) begin
      if (c < NV) drive(1'b1, vt[c]);
      else        drive(1'b0, idle);
      step();
      acc = (c + 1 < NV) ? c + 1 : NV;
      ret = (c - 3 < 0) ? 0 : ((c - 3 > NV) ? NV : c - 3);
      chk($sformatf("str_en_out[%0d]", c), bus.mul_en_out, (c >= 3 && c < NV + 3) ? 1 : 0);
      if (c >= 3 && c < NV + 3) chk($sformatf("str_out[%0d]", c - 3), bus.mul_out, vt[c-3].p);
      chk($sformatf("str_inflight[%0d]", c), bus.inflight, acc - ret);
      chk($sformatf("str_rdy_in[%0d]", c), bus.mul_rdy_in, 1);
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
    end
    chk("str_peak", peak, L);

    // Single unsigned transaction: exact latency, one-cycle pulse, then hold
    drive(1'b1, vt[0]);
    for (int k = 0; k < 5; k++) begin
      step();
      drive(1'b0, idle);
      chk($sformatf("lat_en_out[%0d]", k), bus.mul_en_out, (k == 3) ? 1 : 0);
      if (k >= 3) chk($sformatf("lat_out[%0d]", k), bus.mul_out, 32'hFFFE0001);
    end

    // Fill under backpressure, stall three cycles, then drain
    bus.mul_rdy_out = 1'b0;
    for (int c = 0; c < L; c++) begin
      drive(1'b1, vt[c]);
      step();
    end
    drive(1'b1, junk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_en_out[%0d]", k), bus.mul_en_out, 1);
      chk($sformatf("bp_out[%0d]", k), bus.mul_out, vt[0].p);
      chk($sformatf("bp_rdy_in[%0d]", k), bus.mul_rdy_in, 0);
      chk($sformatf("bp_inflight[%0d]", k), bus.inflight, L);
      step();
    end
    chk("bp_hold_out", bus.mul_out, vt[0].p);
    chk("bp_hold_inflight", bus.inflight, L);
    drive(1'b0, idle);
    bus.mul_rdy_out = 1'b1;
    for (int k = 1; k <= L; k++) begin
      step();
      chk($sformatf("drain_en_out[%0d]", k), bus.mul_en_out, (k < L) ? 1 : 0);
      if (k < L) chk($sformatf("drain_out[%0d]", k), bus.mul_out, vt[k].p);
      chk($sformatf("drain_inflight[%0d]", k), bus.inflight, L - k);
    end

    // Reset with three transactions in flight
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, vt[c + 5]);
      step();
    end
    drive(1'b0, idle);
    chk("mid_inflight_pre", bus.inflight, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_inflight", bus.inflight, 0);
    chk("mid_mul_out", bus.mul_out, 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("mid_en_out[%0d]", k), bus.mul_en_out, 0);
      step();
    end
    chk("mid_inflight_end", bus.inflight, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
